// File: rtl/irq_ctrl.sv
// Bus-mapped interrupt controller: NIRQ pending channels with mask, edge/level mode, global enable.
// Define IRQC_SYNC_EN to add a 2-flop synchroniser on every irq_in bit.
module irq_ctrl #(
  parameter int WIDTH = 32,
  parameter int NIRQ  = 8,
  parameter int IDXW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             wen,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic [NIRQ-1:0]  irq_in,
  output logic             irq,
  output logic [IDXW:0]    vec
);

  localparam logic [2:0] A_PEND = 3'd0;
  localparam logic [2:0] A_MASK = 3'd1;
  localparam logic [2:0] A_MODE = 3'd2;
  localparam logic [2:0] A_VEC  = 3'd3;
  localparam logic [2:0] A_SET  = 3'd4;
  localparam logic [2:0] A_CTRL = 3'd5;
  localparam logic [2:0] A_RAW  = 3'd6;

  logic [NIRQ-1:0] s_s;
  logic [NIRQ-1:0] s_prev_q, s_prev_d;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [NIRQ-1:0] mask_q, mask_d;
  logic [NIRQ-1:0] mode_q, mode_d;
  logic            gie_q, gie_d;
  logic            irq_q, irq_d;

  logic            wr_s;
  logic [NIRQ-1:0] rise_s, set_s, clr_s, ack_s, active_s;
  logic [IDXW-1:0] ack_idx_s, vec_idx_s;
  logic            vec_valid_s;
  logic            unused_din_s;

  assign unused_din_s = ^din;

`ifdef IRQC_SYNC_EN
  logic [NIRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  // synchroniser next-state
  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
  end

  // synchroniser flops
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign s_s = sync2_q;
`else
  assign s_s = irq_in;
`endif

  assign active_s = pend_q & mask_q;

  // priority encode: lowest active index wins
  always_comb begin
    vec_valid_s = |active_s;
    vec_idx_s   = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      vec_idx_s = active_s[i] ? IDXW'(i) : vec_idx_s;
    end
  end

  assign vec = {vec_valid_s, vec_idx_s};

  // next-state for registers and pending bits
  always_comb begin
    wr_s      = cs & wen;
    mask_d    = mask_q;
    mode_d    = mode_q;
    gie_d     = gie_q;
    s_prev_d  = s_s;
    irq_d     = gie_q & (|active_s);
    ack_idx_s = din[IDXW-1:0];
    case ({wr_s, addr})
      {1'b1, A_MASK}: mask_d = din[NIRQ-1:0];
      {1'b1, A_MODE}: mode_d = din[NIRQ-1:0];
      {1'b1, A_CTRL}: gie_d  = din[0];
      default:        mask_d = mask_q;
    endcase
    for (int i = 0; i < NIRQ; i++) begin
      ack_s[i] = (wr_s && addr == A_VEC && ack_idx_s == IDXW'(i)) ? 1'b1 : 1'b0;
    end
    rise_s = s_s & ~s_prev_q;
    set_s  = rise_s | ((wr_s && addr == A_SET) ? din[NIRQ-1:0] : {NIRQ{1'b0}});
    clr_s  = ack_s | ((wr_s && addr == A_PEND) ? din[NIRQ-1:0] : {NIRQ{1'b0}});
    // set beats clear on edge channels; level channels simply follow s
    pend_d = (mode_q & (set_s | (pend_q & ~clr_s))) | (~mode_q & s_s);
  end

  // state flops
  always_ff @(posedge clk) begin
    if (reset) begin
      s_prev_q <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
      gie_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      s_prev_q <= s_prev_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      gie_q    <= gie_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;

  // read mux, zero when not selected
  always_comb begin
    dout = '0;
    case ({cs, addr})
      {1'b1, A_PEND}: dout = WIDTH'(pend_q);
      {1'b1, A_MASK}: dout = WIDTH'(mask_q);
      {1'b1, A_MODE}: dout = WIDTH'(mode_q);
      {1'b1, A_VEC}: begin
        dout[WIDTH-1]  = vec_valid_s;
        dout[IDXW-1:0] = vec_idx_s;
      end
      {1'b1, A_CTRL}: dout = WIDTH'(gie_q);
      {1'b1, A_RAW}:  dout = WIDTH'(s_s);
      default:        dout = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed-vector bench for irq_ctrl; latency expectations adapt to IRQC_SYNC_EN.
module tb_irq_ctrl;

`ifdef IRQC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic        wen = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic [7:0]  irq_in = 8'd0;
  logic        irq;
  logic [5:0]  vec;

  int n_vec = 0;
  int n_miss = 0;

  irq_ctrl #(.WIDTH(32), .NIRQ(8), .IDXW(5)) dut (
    .clk(clk), .reset(reset), .cs(cs), .wen(wen), .addr(addr), .din(din),
    .dout(dout), .irq_in(irq_in), .irq(irq), .vec(vec)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; wen = 1'b1; addr = a; din = d;
    step();
    cs = 1'b0; wen = 1'b0; din = 32'd0;
  endtask

  task automatic rdchk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    cs = 1'b1; wen = 1'b0; addr = a;
    #1;
    chk(tag, dout, exp);
    cs = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;

    // reset state
    for (int a = 0; a < 8; a++) rdchk($sformatf("reset_reg%0d", a), 3'(a), 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_vec", {26'd0, vec}, 32'd0);

    // all inputs high, nothing masked
    irq_in = 8'hFF;
    repeat (LAT + 2) step();
    rdchk("raw_ff", 3'd6, 32'h0000_00FF);
    rdchk("level_pend_ff", 3'd0, 32'h0000_00FF);
    chk("masked_irq", {31'd0, irq}, 32'd0);
    chk("masked_vec", {26'd0, vec}, 32'd0);
    irq_in = 8'h00;
    repeat (LAT + 2) step();
    rdchk("level_pend_clr", 3'd0, 32'd0);

    // edge latency on channel 0 with a one-cycle pulse
    wr(3'd2, 32'h01);
    wr(3'd1, 32'h01);
    wr(3'd5, 32'h01);
    rdchk("ctrl_rb", 3'd5, 32'h1);
    irq_in = 8'h01;
    step();
    irq_in = 8'h00;
    for (int j = 0; j <= LAT + 3; j++) begin
      chk($sformatf("edge_irq_k%0d", j), {31'd0, irq}, (j >= LAT + 1) ? 32'd1 : 32'd0);
      step();
    end
    rdchk("edge_vec", 3'd3, 32'h8000_0000);
    wr(3'd3, 32'd0);
    chk("ack_irq_hold", {31'd0, irq}, 32'd1);
    step();
    chk("ack_irq_drop", {31'd0, irq}, 32'd0);
    rdchk("ack_pend", 3'd0, 32'd0);

    // priority among software-set edge channels
    wr(3'd2, 32'hFF);
    wr(3'd1, 32'hFF);
    wr(3'd4, 32'hA4);
    rdchk("prio_pend", 3'd0, 32'h0000_00A4);
    rdchk("prio_vec2", 3'd3, 32'h8000_0002);
    chk("prio_vecport", {26'd0, vec}, 32'h22);
    rdchk("set_reads0", 3'd4, 32'd0);
    rdchk("rsvd_reads0", 3'd7, 32'd0);
    wr(3'd3, 32'd2);
    rdchk("prio_vec5", 3'd3, 32'h8000_0005);
    wr(3'd3, 32'd9);
    rdchk("ack_oob_ignored", 3'd3, 32'h8000_0005);
    wr(3'd3, 32'd5);
    rdchk("prio_vec7", 3'd3, 32'h8000_0007);
    chk("prio_irq_on", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'd7);
    rdchk("prio_vec_none", 3'd3, 32'd0);
    step();
    chk("prio_irq_off", {31'd0, irq}, 32'd0);

    // level mode on channel 3
    wr(3'd2, 32'h00);
    wr(3'd1, 32'h08);
    irq_in = 8'h08;
    repeat (LAT + 2) step();
    rdchk("level_pend", 3'd0, 32'h08);
    chk("level_irq", {31'd0, irq}, 32'd1);
    wr(3'd0, 32'h08);
    rdchk("level_w1c_ignored", 3'd0, 32'h08);
    irq_in = 8'h00;
    repeat (LAT + 2) step();
    rdchk("level_release_pend", 3'd0, 32'd0);
    chk("level_release_irq", {31'd0, irq}, 32'd0);

    // set/clear collision on edge channel 1
    wr(3'd1, 32'h00);
    wr(3'd2, 32'h02);
    wr(3'd4, 32'h02);
    irq_in = 8'h02;
    repeat (LAT) step();
    wr(3'd0, 32'h02);
    rdchk("collision_set_wins", 3'd0, 32'h02);
    wr(3'd0, 32'h02);
    rdchk("w1c_clears", 3'd0, 32'd0);
    irq_in = 8'h00;
    repeat (LAT + 2) step();

    // global enable and mask gating on channel 4
    wr(3'd2, 32'h10);
    wr(3'd1, 32'h10);
    wr(3'd5, 32'h00);
    wr(3'd4, 32'h10);
    step();
    chk("gate_irq_gie0", {31'd0, irq}, 32'd0);
    chk("gate_vec", {26'd0, vec}, 32'h24);
    wr(3'd5, 32'h01);
    chk("gate_irq_lat", {31'd0, irq}, 32'd0);
    step();
    chk("gate_irq_on", {31'd0, irq}, 32'd1);
    wr(3'd1, 32'h00);
    step();
    chk("mask_irq_off", {31'd0, irq}, 32'd0);
    rdchk("mask_pend_kept", 3'd0, 32'h10);
    cs = 1'b0; addr = 3'd0;
    #1;
    chk("cs_low_dout", dout, 32'd0);

    // reset mid-event discards pending
    reset = 1'b1;
    step();
    reset = 1'b0;
    rdchk("rst_pend", 3'd0, 32'd0);
    rdchk("rst_mask", 3'd1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
